// File: rtl/dbus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dbus_ctrl_pkg
// Shared definitions for the data-bus access controller:
//   - FSM state encoding (dbus_state_t)
//   - default bus-wait timeout and minimum wait-counter width
//   - byte-lane mask constants (bit3 = data[31:24], big-endian lane order)
//   - misaligned(): alignment check for word / halfword lane masks
// -----------------------------------------------------------------------------
package dbus_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } dbus_state_t;

   localparam int TIMEOUT_CYC_DEF = 16;
   localparam int TMR_W_MIN       = 8;

   localparam logic [3:0] SEL_WORD    = 4'b1111;
   localparam logic [3:0] SEL_HALF_HI = 4'b1100;
   localparam logic [3:0] SEL_HALF_LO = 4'b0011;

   // Access size is inferred from the lane mask. Byte accesses (single lane)
   // are always aligned; any other mask pattern is not checked.
   function automatic logic misaligned(input logic [3:0] sel,
                                       input logic [1:0] addr_lo);
      logic res;
      res = 1'b0;
      if (sel == SEL_WORD)
         res = (addr_lo != 2'b00);
      else if ((sel == SEL_HALF_HI) || (sel == SEL_HALF_LO))
         res = addr_lo[0];
      return res;
   endfunction

endpackage

// File: rtl/dbus_ctrl_timer.sv
// -----------------------------------------------------------------------------
// dbus_timer
// Bus-wait counter: synchronous clear, count enable, saturating count and an
// expire flag.
//   clk       in   clock
//   rst       in   asynchronous active-low reset
//   i_clear   in   clear count to 0 (wins over enable)
//   i_en      in   count this cycle (a bus cycle is outstanding)
//   o_expire  out  this enabled cycle is the LIMIT-th one since the clear
// -----------------------------------------------------------------------------
module dbus_timer #(
   parameter int LIMIT = 16,
   parameter int W     = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expire
);

   localparam logic [W-1:0] LAST = W'(LIMIT - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_count <= '0;
      else if (i_clear)
         r_count <= '0;
      else if (i_en && (r_count != '1))
         r_count <= r_count + 1'b1;
   end

   // Count is 0 in the first enabled cycle, so LIMIT-1 marks the LIMIT-th.
   assign o_expire = i_en && (r_count >= LAST);

endmodule

// File: rtl/dbus_ctrl.sv
// -----------------------------------------------------------------------------
// dbus_ctrl
// Memory-stage data-bus controller. Turns one mem-stage load/store request
// into a single classic bus cycle (cyc/stb/ack/err), stalls the pipeline while
// the access is outstanding and returns load data / error for one cycle.
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-low reset
//   req_ce_i       in   mem-stage access enable
//   req_wr_i       in   1 = store, 0 = load
//   req_sel_i      in   byte-lane mask, bit3 = data[31:24]
//   req_addr_i     in   byte address
//   req_wdata_i    in   store data, already lane-replicated
//   flush_i        in   cancel the current mem-stage instruction
//   rdata_o        out  load data, valid only in the DONE cycle
//   stallreq_o     out  stall request to pipeline control
//   err_o          out  one-cycle bus error / timeout / misalign pulse
//   bus_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o  out  bus master outputs
//   bus_dat_i/ack_i/err_i                   in   bus slave responses
// -----------------------------------------------------------------------------
module dbus_ctrl
   import dbus_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
   parameter bit ADDR_ALIGN_CHK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_ce_i,
   input  logic        req_wr_i,
   input  logic [3:0]  req_sel_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic        flush_i,
   output logic [31:0] rdata_o,
   output logic        stallreq_o,
   output logic        err_o,
   output logic        bus_cyc_o,
   output logic        bus_stb_o,
   output logic        bus_we_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_adr_o,
   output logic [31:0] bus_dat_o,
   input  logic [31:0] bus_dat_i,
   input  logic        bus_ack_i,
   input  logic        bus_err_i
);

   localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : TMR_W_MIN;

   dbus_state_t r_state;
   dbus_state_t w_state_next;

   logic [31:2] r_adr;
   logic [3:0]  r_sel;
   logic        r_we;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;

   logic w_misalign;
   logic w_expire;
   logic w_bus_end;
   logic w_fail;
   logic w_bus_act;
   logic w_stall;
   logic w_issue;
   logic w_capture;
   logic w_err_next;
   logic w_tmr_clear;

   assign w_misalign = ADDR_ALIGN_CHK && misaligned(req_sel_i, req_addr_i[1:0]);
   assign w_fail     = bus_err_i || w_expire;      // err beats a same-cycle ack
   assign w_bus_end  = bus_ack_i || w_fail;
   assign w_bus_act  = (r_state == ST_WAIT) || (r_state == ST_DRAIN);

   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_issue      = 1'b0;
      w_capture    = 1'b0;
      w_err_next   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_ce_i && !flush_i) begin
               w_stall = 1'b1;
               if (w_misalign) begin
                  // No bus cycle: report the error in the DONE slot.
                  w_state_next = ST_DONE;
                  w_err_next   = 1'b1;
               end else begin
                  w_issue      = 1'b1;
                  w_state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (flush_i) begin
               // Instruction is gone; let the bus cycle finish silently.
               // If the slave answers this very cycle there is nothing to drain.
               w_state_next = w_bus_end ? ST_IDLE : ST_DRAIN;
            end else begin
               w_stall = 1'b1;
               if (w_fail) begin
                  w_state_next = ST_DONE;
                  w_err_next   = 1'b1;
               end else if (bus_ack_i) begin
                  w_state_next = ST_DONE;
                  w_capture    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
         end
         ST_DRAIN: begin
            // A younger request must wait until the bus is free again.
            w_stall = req_ce_i && !flush_i;
            if (w_bus_end)
               w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Fresh timeout window on every entry into WAIT or DRAIN.
   assign w_tmr_clear = ((w_state_next == ST_WAIT) || (w_state_next == ST_DRAIN))
                        && (w_state_next != r_state);

   dbus_timer #(
      .LIMIT (TIMEOUT_CYC),
      .W     (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_tmr_clear),
      .i_en     (w_bus_act),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_adr   <= '0;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_err   <= w_err_next;
         if (w_issue) begin
            r_adr   <= req_addr_i[31:2];
            r_sel   <= req_sel_i;
            r_we    <= req_wr_i;
            r_wdata <= req_wdata_i;
         end
         if (w_err_next)
            r_rdata <= '0;
         else if (w_capture)
            r_rdata <= r_we ? 32'd0 : bus_dat_i;
      end
   end

   // Bus outputs come only from the latched request and are zero when idle.
   assign bus_cyc_o = w_bus_act;
   assign bus_stb_o = w_bus_act;
   assign bus_we_o  = w_bus_act & r_we;
   assign bus_sel_o = w_bus_act ? r_sel : 4'd0;
   assign bus_adr_o = w_bus_act ? {r_adr, 2'b00} : 32'd0;
   assign bus_dat_o = w_bus_act ? r_wdata : 32'd0;

   assign rdata_o    = (r_state == ST_DONE) ? r_rdata : 32'd0;
   assign err_o      = r_err;
   // The request path is combinational, so mask it while reset is held.
   assign stallreq_o = w_stall & rst;

endmodule

// File: tb/tb_dbus_ctrl.sv
module tb_dbus_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_ce_i;
   logic        req_wr_i;
   logic [3:0]  req_sel_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        flush_i;
   logic [31:0] rdata_o;
   logic        stallreq_o;
   logic        err_o;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_adr_o;
   logic [31:0] bus_dat_o;
   logic [31:0] bus_dat_i;
   logic        bus_ack_i;
   logic        bus_err_i;

   int n_checks = 0;
   int n_errors = 0;

   dbus_ctrl dut (
      .clk         (clk),
      .rst         (rst_n),
      .req_ce_i    (req_ce_i),
      .req_wr_i    (req_wr_i),
      .req_sel_i   (req_sel_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .flush_i     (flush_i),
      .rdata_o     (rdata_o),
      .stallreq_o  (stallreq_o),
      .err_o       (err_o),
      .bus_cyc_o   (bus_cyc_o),
      .bus_stb_o   (bus_stb_o),
      .bus_we_o    (bus_we_o),
      .bus_sel_o   (bus_sel_o),
      .bus_adr_o   (bus_adr_o),
      .bus_dat_o   (bus_dat_o),
      .bus_dat_i   (bus_dat_i),
      .bus_ack_i   (bus_ack_i),
      .bus_err_i   (bus_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ce;
      logic        wr;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        flush;
      logic [31:0] dat;
      logic        ack;
      logic        err;
      logic        x_stall;
      logic        x_err;
      logic        x_cyc;
      logic        x_we;
      logic [3:0]  x_sel;
      logic [31:0] x_adr;
      logic [31:0] x_dat;
      logic [31:0] x_rdata;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ce, input logic wr, input logic [3:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic flush, input logic [31:0] dat,
                      input logic ack, input logic err,
                      input logic x_stall, input logic x_err, input logic x_cyc,
                      input logic x_we, input logic [3:0] x_sel,
                      input logic [31:0] x_adr, input logic [31:0] x_dat,
                      input logic [31:0] x_rdata);
      vec_t v;
      v.ce = ce; v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata;
      v.flush = flush; v.dat = dat; v.ack = ack; v.err = err;
      v.x_stall = x_stall; v.x_err = x_err; v.x_cyc = x_cyc; v.x_we = x_we;
      v.x_sel = x_sel; v.x_adr = x_adr; v.x_dat = x_dat; v.x_rdata = x_rdata;
      vecs.push_back(v);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ce, input logic wr, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic flush, input logic [31:0] dat,
                        input logic ack, input logic err);
      req_ce_i = ce; req_wr_i = wr; req_sel_i = sel; req_addr_i = addr;
      req_wdata_i = wdata; flush_i = flush; bus_dat_i = dat;
      bus_ack_i = ack; bus_err_i = err;
   endtask

   task automatic chk_all_zero(input string tag);
      chk1({tag, " stall"}, stallreq_o, 1'b0);
      chk1({tag, " err"},   err_o,      1'b0);
      chk1({tag, " cyc"},   bus_cyc_o,  1'b0);
      chk1({tag, " stb"},   bus_stb_o,  1'b0);
      chk1({tag, " we"},    bus_we_o,   1'b0);
      chk32({tag, " sel"},   32'(bus_sel_o), 32'd0);
      chk32({tag, " adr"},   bus_adr_o, 32'd0);
      chk32({tag, " dat"},   bus_dat_o, 32'd0);
      chk32({tag, " rdata"}, rdata_o,   32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int waits;
      logic got;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

      // Load 0x100, ack in 3rd bus cycle
      add(1,0,4'hF,32'h100,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(1,0,4'hF,32'h100,0,0,0,0,0,           1,0,1,0,4'hF,32'h100,0,0);
      add(1,0,4'hF,32'h100,0,0,0,0,0,           1,0,1,0,4'hF,32'h100,0,0);
      add(1,0,4'hF,32'h100,0,0,32'hDEADBEEF,1,0, 1,0,1,0,4'hF,32'h100,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,32'hDEADBEEF);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // Half store 0x202, request lines scrambled while waiting
      add(1,1,4'h3,32'h202,32'hBEEFBEEF,0,0,0,0,          1,0,0,0,4'h0,0,0,0);
      add(1,0,4'hF,32'hFFFFFFFC,32'h0,0,0,1,0,            1,0,1,1,4'h3,32'h200,32'hBEEFBEEF,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // Misaligned word load 0x101
      add(1,0,4'hF,32'h101,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,1,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // Misaligned upper-half load 0x203
      add(1,0,4'hC,32'h203,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,1,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // Byte load at odd address is legal
      add(1,0,4'h4,32'h101,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(1,0,4'h4,32'h101,0,0,32'h00AB0000,1,0, 1,0,1,0,4'h4,32'h100,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,32'h00AB0000);
      // Ack and err together: err wins
      add(1,0,4'hF,32'h104,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(1,0,4'hF,32'h104,0,0,32'h12345678,1,1, 1,0,1,0,4'hF,32'h104,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,1,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // Flush in IDLE: nothing issued
      add(1,0,4'hF,32'h108,0,1,0,0,0,           0,0,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // Flush in WAIT cycle 1, ack in cycle 4
      add(1,0,4'hF,32'h10C,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(1,0,4'hF,32'h10C,0,1,0,0,0,           0,0,1,0,4'hF,32'h10C,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,1,0,4'hF,32'h10C,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,1,0,4'hF,32'h10C,0,0);
      add(0,0,4'h0,0,0,0,32'hAAAA5555,1,0,      0,0,1,0,4'hF,32'h10C,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);
      // New request arriving while draining
      add(1,0,4'hF,32'h110,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(1,0,4'hF,32'h110,0,1,0,0,0,           0,0,1,0,4'hF,32'h110,0,0);
      add(1,0,4'hF,32'h114,0,0,0,0,0,           1,0,1,0,4'hF,32'h110,0,0);
      add(1,0,4'hF,32'h114,0,0,32'h55555555,1,0, 1,0,1,0,4'hF,32'h110,0,0);
      add(1,0,4'hF,32'h114,0,0,0,0,0,           1,0,0,0,4'h0,0,0,0);
      add(1,0,4'hF,32'h114,0,0,32'hCAFEF00D,1,0, 1,0,1,0,4'hF,32'h114,0,0);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,32'hCAFEF00D);
      add(0,0,4'h0,0,0,0,0,0,0,                 0,0,0,0,4'h0,0,0,0);

      // Reset state
      repeat (2) @(negedge clk);
      #2;
      chk_all_zero("reset");
      $display("reset: outputs sampled while rst low");
      rst_n = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].ce, vecs[i].wr, vecs[i].sel, vecs[i].addr, vecs[i].wdata,
               vecs[i].flush, vecs[i].dat, vecs[i].ack, vecs[i].err);
         #2;
         chk1($sformatf("v%0d stall", i), stallreq_o, vecs[i].x_stall);
         chk1($sformatf("v%0d err", i), err_o, vecs[i].x_err);
         chk1($sformatf("v%0d cyc", i), bus_cyc_o, vecs[i].x_cyc);
         chk1($sformatf("v%0d stb", i), bus_stb_o, vecs[i].x_cyc);
         chk32($sformatf("v%0d rdata", i), rdata_o, vecs[i].x_rdata);
         if (vecs[i].x_cyc) begin
            chk1($sformatf("v%0d we", i), bus_we_o, vecs[i].x_we);
            chk32($sformatf("v%0d sel", i), 32'(bus_sel_o), 32'(vecs[i].x_sel));
            chk32($sformatf("v%0d adr", i), bus_adr_o, vecs[i].x_adr);
            if (vecs[i].x_we)
               chk32($sformatf("v%0d dat", i), bus_dat_o, vecs[i].x_dat);
         end
         $display("vec %0d: ce=%0b flush=%0b ack=%0b err_i=%0b -> stall=%0b cyc=%0b err=%0b adr=%h rdata=%h",
                  i, vecs[i].ce, vecs[i].flush, vecs[i].ack, vecs[i].err,
                  stallreq_o, bus_cyc_o, err_o, bus_adr_o, rdata_o);
      end

      // Timeout: load with no ack ever
      @(negedge clk);
      drive(1'b1, 1'b0, 4'hF, 32'h120, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk1("tmo issue stall", stallreq_o, 1'b1);
      waits = 0;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         #2;
         if (err_o)
            got = 1'b1;
         else if (bus_cyc_o)
            waits++;
      end
      chk1("tmo err seen", got, 1'b1);
      chk32("tmo wait cycles", 32'(waits), 32'd16);
      chk32("tmo rdata", rdata_o, 32'd0);
      chk1("tmo stall", stallreq_o, 1'b0);
      chk1("tmo cyc", bus_cyc_o, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk1("tmo err pulse end", err_o, 1'b0);
      chk1("tmo idle cyc", bus_cyc_o, 1'b0);
      $display("timeout: %0d wait cycles, err seen=%0b", waits, got);

      // Reset in the middle of WAIT
      @(negedge clk);
      drive(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk1("rstw issue stall", stallreq_o, 1'b1);
      @(negedge clk);
      #2;
      chk1("rstw wait cyc", bus_cyc_o, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rstw async");
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      chk_all_zero("rstw held");
      rst_n = 1'b1;
      @(negedge clk);
      drive(1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk1("rstw post err", err_o, 1'b0);
      chk1("rstw post stall", stallreq_o, 1'b1);
      chk1("rstw post idle cyc", bus_cyc_o, 1'b0);
      @(negedge clk);
      drive(1'b1, 1'b0, 4'hF, 32'h304, 32'h0, 1'b0, 32'h0BADF00D, 1'b1, 1'b0);
      #2;
      chk1("rstw new cyc", bus_cyc_o, 1'b1);
      chk32("rstw new adr", bus_adr_o, 32'h304);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #2;
      chk32("rstw new rdata", rdata_o, 32'h0BADF00D);
      chk1("rstw new err", err_o, 1'b0);
      chk1("rstw new stall", stallreq_o, 1'b0);
      $display("reset-mid-wait: follow-up load rdata=%h", rdata_o);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
